// File: rtl/axi_lite_ram_if.sv
// AXI4-Lite bus bundle between a master and the RAM-backed responder.
interface axi_lite_ram_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] s_araddr;
  logic                  s_arvalid;
  logic                  s_arready;
  logic [2:0]            s_arprot;
  logic [31:0]           s_rdata;
  logic [1:0]            s_rresp;
  logic                  s_rvalid;
  logic                  s_rready;
  logic [ADDR_WIDTH-1:0] s_awaddr;
  logic                  s_awvalid;
  logic                  s_awready;
  logic [2:0]            s_awprot;
  logic [31:0]           s_wdata;
  logic [3:0]            s_wstrb;
  logic                  s_wvalid;
  logic                  s_wready;
  logic [1:0]            s_bresp;
  logic                  s_bvalid;
  logic                  s_bready;

  modport master (
    output s_araddr, s_arvalid, s_arprot, s_rready,
    output s_awaddr, s_awvalid, s_awprot, s_wdata, s_wstrb, s_wvalid, s_bready,
    input  s_arready, s_rdata, s_rresp, s_rvalid,
    input  s_awready, s_wready, s_bresp, s_bvalid
  );

  modport slave (
    input  s_araddr, s_arvalid, s_arprot, s_rready,
    input  s_awaddr, s_awvalid, s_awprot, s_wdata, s_wstrb, s_wvalid, s_bready,
    output s_arready, s_rdata, s_rresp, s_rvalid,
    output s_awready, s_wready, s_bresp, s_bvalid
  );
endinterface

// File: rtl/axi_lite_ram_slave.sv
// AXI4-Lite responder over a word-addressed RAM; independent read and write FSMs,
// AW/W in any order, byte strobes, SLVERR beyond DEPTH.
module axi_lite_ram_slave #(
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 1024
) (
  input logic clk,
  input logic rstn,
  axi_lite_ram_if.slave s
);
  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_READ = 2'd1, R_RESP = 2'd2} rd_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_EXEC = 2'd1, W_RESP = 2'd2} wr_state_t;

  logic [31:0]      mem_r [DEPTH];
  rd_state_t        rd_state_r;
  wr_state_t        wr_state_r;
  logic [IDX_W-1:0] ar_idx_r;
  logic [IDX_W-1:0] aw_idx_r;
  logic [31:0]      wdata_r;
  logic [3:0]       wstrb_r;
  logic             aw_got_r;
  logic             w_got_r;

  logic ar_in_range_s;
  logic aw_in_range_s;
  logic aw_hs_s;
  logic w_hs_s;
  logic ram_we_s;
  logic unused_s;

  // Extra top bit keeps the compare correct when DEPTH equals 2^IDX_W.
  assign ar_in_range_s = ({1'b0, ar_idx_r} < (IDX_W + 1)'(DEPTH));
  assign aw_in_range_s = ({1'b0, aw_idx_r} < (IDX_W + 1)'(DEPTH));
  assign aw_hs_s       = s.s_awvalid && s.s_awready;
  assign w_hs_s        = s.s_wvalid && s.s_wready;
  assign ram_we_s      = rstn && (wr_state_r == W_EXEC) && aw_in_range_s;
  assign unused_s      = ^{s.s_arprot, s.s_awprot, s.s_araddr[1:0], s.s_awaddr[1:0]};

  // RAM byte-lane write; gated by rstn so a reset during W_EXEC drops the write.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_r[i]) begin
          mem_r[aw_idx_r[MEM_AW-1:0]][8*i +: 8] <= wdata_r[8*i +: 8];
        end
      end
    end
  end

  // Read channel FSM; RAM read happens here so a same-cycle write is seen as old data.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_state_r  <= R_IDLE;
      ar_idx_r    <= '0;
      s.s_arready <= 1'b1;
      s.s_rvalid  <= 1'b0;
      s.s_rdata   <= 32'h0000_0000;
      s.s_rresp   <= RESP_OKAY;
    end else begin
      case (rd_state_r)
        R_IDLE: begin
          if (s.s_arvalid && s.s_arready) begin
            ar_idx_r    <= s.s_araddr[ADDR_WIDTH-1:2];
            s.s_arready <= 1'b0;
            rd_state_r  <= R_READ;
          end
        end
        R_READ: begin
          s.s_rdata  <= ar_in_range_s ? mem_r[ar_idx_r[MEM_AW-1:0]] : 32'h0000_0000;
          s.s_rresp  <= ar_in_range_s ? RESP_OKAY : RESP_SLVERR;
          s.s_rvalid <= 1'b1;
          rd_state_r <= R_RESP;
        end
        R_RESP: begin
          if (s.s_rvalid && s.s_rready) begin
            s.s_rvalid  <= 1'b0;
            s.s_arready <= 1'b1;
            rd_state_r  <= R_IDLE;
          end
        end
        default: begin
          s.s_rvalid  <= 1'b0;
          s.s_arready <= 1'b1;
          rd_state_r  <= R_IDLE;
        end
      endcase
    end
  end

  // Write channel FSM; AW and W captured independently, executed once both are held.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_state_r  <= W_IDLE;
      aw_idx_r    <= '0;
      wdata_r     <= 32'h0000_0000;
      wstrb_r     <= 4'h0;
      aw_got_r    <= 1'b0;
      w_got_r     <= 1'b0;
      s.s_awready <= 1'b1;
      s.s_wready  <= 1'b1;
      s.s_bvalid  <= 1'b0;
      s.s_bresp   <= RESP_OKAY;
    end else begin
      case (wr_state_r)
        W_IDLE: begin
          if (aw_hs_s) begin
            aw_idx_r    <= s.s_awaddr[ADDR_WIDTH-1:2];
            aw_got_r    <= 1'b1;
            s.s_awready <= 1'b0;
          end
          if (w_hs_s) begin
            wdata_r    <= s.s_wdata;
            wstrb_r    <= s.s_wstrb;
            w_got_r    <= 1'b1;
            s.s_wready <= 1'b0;
          end
          if ((aw_got_r || aw_hs_s) && (w_got_r || w_hs_s)) begin
            wr_state_r <= W_EXEC;
          end
        end
        W_EXEC: begin
          s.s_bresp  <= aw_in_range_s ? RESP_OKAY : RESP_SLVERR;
          s.s_bvalid <= 1'b1;
          wr_state_r <= W_RESP;
        end
        W_RESP: begin
          if (s.s_bvalid && s.s_bready) begin
            s.s_bvalid  <= 1'b0;
            aw_got_r    <= 1'b0;
            w_got_r     <= 1'b0;
            s.s_awready <= 1'b1;
            s.s_wready  <= 1'b1;
            wr_state_r  <= W_IDLE;
          end
        end
        default: begin
          s.s_bvalid  <= 1'b0;
          aw_got_r    <= 1'b0;
          w_got_r     <= 1'b0;
          s.s_awready <= 1'b1;
          s.s_wready  <= 1'b1;
          wr_state_r  <= W_IDLE;
        end
      endcase
    end
  end
endmodule
